imem_fetch_ctrl: RTL and testbench



---
 rtl/imem_fetch_ctrl.sv | 110 +++++++++++
 tb/tb_imem_fetch_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory port owner: arbitrates loader writes against IF fetches and
// keeps the fetch PC plus a 2-entry prefetch buffer feeding IF/ID.
module imem_fetch_ctrl #(
  parameter int          ADDR_W    = 6,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_instr,
  output logic [31:0]       if_pc,
  output logic              if_fault,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              state_run
);

  localparam logic ST_LOAD = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic        state_reg;
  logic [31:0] fpc_reg;
  logic [1:0]  count_reg;
  logic [31:0] pc0_reg, pc1_reg;
  logic [31:0] instr0_reg, instr1_reg;
  logic        fault0_reg, fault1_reg;

  logic        out_of_range;
  logic        fetch;
  logic        pop;
  logic [31:0] new_instr;

  // The loader always wins the port; a write is accepted the cycle it is offered.
  assign ld_ready  = ld_valid & ~rst;
  assign mem_we    = ld_ready;
  assign mem_wdata = ld_data;

  assign out_of_range = (fpc_reg[31:ADDR_W+2] != '0) || (fpc_reg[1:0] != 2'b00);
  assign fetch        = (state_reg == ST_RUN) && !ld_valid && !redirect_valid &&
                        (count_reg != 2'd2);
  assign mem_addr     = ld_ready ? ld_addr : fpc_reg[ADDR_W+1:2];
  assign new_instr    = out_of_range ? NOP_INSTR : mem_rdata;

  assign if_valid  = (count_reg != 2'd0);
  assign if_instr  = instr0_reg;
  assign if_pc     = pc0_reg;
  assign if_fault  = fault0_reg;
  assign pop       = if_valid & if_ready;
  assign state_run = (state_reg == ST_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_LOAD;
      fpc_reg    <= RESET_PC;
      count_reg  <= 2'd0;
      pc0_reg    <= '0;
      pc1_reg    <= '0;
      instr0_reg <= '0;
      instr1_reg <= '0;
      fault0_reg <= 1'b0;
      fault1_reg <= 1'b0;
    end else if (state_reg == ST_LOAD) begin
      if (redirect_valid) fpc_reg <= redirect_pc;
      if (ld_valid && ld_last) state_reg <= ST_RUN;
    end else if (ld_valid) begin
      // A write may change any buffered word: flush and resume at the oldest
      // instruction not yet handed to IF/ID.
      count_reg <= 2'd0;
      if (redirect_valid)                 fpc_reg <= redirect_pc;
      else if (pop && count_reg == 2'd2)  fpc_reg <= pc1_reg;
      else if (!pop && count_reg != 2'd0) fpc_reg <= pc0_reg;
    end else if (redirect_valid) begin
      count_reg <= 2'd0;
      fpc_reg   <= redirect_pc;
    end else begin
      if (fetch) fpc_reg <= fpc_reg + 32'd4;
      if (pop && count_reg == 2'd2) begin
        // Full buffer never fetches, so a pop here is a plain shift.
        pc0_reg    <= pc1_reg;
        instr0_reg <= instr1_reg;
        fault0_reg <= fault1_reg;
        count_reg  <= 2'd1;
      end else if (fetch && (count_reg == 2'd0 || pop)) begin
        pc0_reg    <= fpc_reg;
        instr0_reg <= new_instr;
        fault0_reg <= out_of_range;
        count_reg  <= 2'd1;
      end else if (fetch) begin
        pc1_reg    <= fpc_reg;
        instr1_reg <= new_instr;
        fault1_reg <= out_of_range;
        count_reg  <= 2'd2;
      end else if (pop) begin
        count_reg  <= count_reg - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: memory model plus a scoreboard of expected
// deliveries, checked whenever IF/ID consumes the buffer head.
module tb_imem_fetch_ctrl;

  localparam int ADDR_W = 6;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_data;
  logic              ld_last;
  logic              if_valid;
  logic              if_ready;
  logic [31:0]       if_instr;
  logic [31:0]       if_pc;
  logic              if_fault;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              state_run;

  imem_fetch_ctrl #(.ADDR_W(ADDR_W), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_last(ld_last),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .if_fault(if_fault),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .state_run(state_run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory seen by the DUT, and the bench's own record of what it wrote.
  logic [31:0] mem  [64];
  logic [31:0] gold [64];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  int we_cnt = 0;
  always @(posedge clk) if (mem_we) we_cnt <= we_cnt + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    total++;
    assert (obs === req) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask

  function automatic void push_exp(input logic [31:0] pc, input logic [31:0] instr,
                                   input logic fault);
    exp_t e;
    e.pc = pc; e.instr = instr; e.fault = fault;
    exp_q.push_back(e);
  endfunction

  // Score a consumption in the current cycle (if any), then advance one clock.
  task automatic step();
    exp_t e;
    if (!rst && if_valid && if_ready && !redirect_valid) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_pc", if_pc, e.pc);
        chk("sb_instr", if_instr, e.instr);
        chk("sb_fault", 32'(if_fault), 32'(e.fault));
        $display("pop pc=%h instr=%h fault=%0d", if_pc, if_instr, if_fault);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_last = 1'b0;
    if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_state_run", 32'(state_run), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_if_fault", 32'(if_fault), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    rst = 1'b0;

    // Boot load of words 0..12
    for (int i = 0; i < 13; i++) begin
      ld_valid = 1'b1; ld_addr = ADDR_W'(i); ld_data = $urandom; ld_last = (i == 12);
      gold[i] = ld_data;
      #1;
      chk("load_ld_ready", 32'(ld_ready), 32'd1);
      chk("load_mem_addr", 32'(mem_addr), i);
      chk("load_state", 32'(state_run), 32'd0);
      $display("load addr=%0d data=%h", i, ld_data);
      step();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("boot_we_pulses", we_cnt, 32'd13);
    chk("boot_state_run", 32'(state_run), 32'd1);
    chk("boot_no_early_valid", 32'(if_valid), 32'd0);
    step();
    chk("boot_first_valid", 32'(if_valid), 32'd1);
    chk("boot_first_pc", if_pc, 32'd0);

    // Streaming at one per cycle
    for (int k = 0; k < 6; k++) push_exp(32'(k * 4), gold[k], 1'b0);
    if_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("stream_valid", 32'(if_valid), 32'd1);
      step();
    end
    if_ready = 1'b0;
    chk("stream_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure from pc 0
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    step();
    redirect_valid = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("bp_valid", 32'(if_valid), 32'd1);
    chk("bp_head_pc", if_pc, 32'd0);
    chk("bp_fpc_held", 32'(mem_addr), 32'd2);
    for (int k = 0; k < 4; k++) push_exp(32'(k * 4), gold[k], 1'b0);
    if_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("bp_no_gap", 32'(if_valid), 32'd1);
      step();
    end
    if_ready = 1'b0;
    chk("bp_drained", 32'(exp_q.size()), 32'd0);
    step(); step();

    // Redirect with a full buffer, head at 0x10, if_ready ignored
    chk("rd_head_pc", if_pc, 32'h10);
    chk("rd_full_hold", 32'(mem_addr), 32'd6);
    redirect_valid = 1'b1; redirect_pc = 32'h24; if_ready = 1'b1;
    step();
    redirect_valid = 1'b0; if_ready = 1'b0;
    chk("rd_bubble", 32'(if_valid), 32'd0);
    step();
    chk("rd_valid", 32'(if_valid), 32'd1);
    chk("rd_pc", if_pc, 32'h24);
    chk("rd_instr", if_instr, gold[9]);

    // RUN-mode write with buffer {0x8,0xC}
    redirect_valid = 1'b1; redirect_pc = 32'h8;
    step();
    redirect_valid = 1'b0;
    step(); step(); step();
    chk("wr_head_pc", if_pc, 32'h8);
    ld_valid = 1'b1; ld_addr = 6'd3; ld_data = 32'hDEAD_BEEF; gold[3] = 32'hDEAD_BEEF;
    #1;
    chk("wr_mem_we", 32'(mem_we), 32'd1);
    chk("wr_mem_addr", 32'(mem_addr), 32'd3);
    $display("run write addr=3 data=%h", ld_data);
    step();
    ld_valid = 1'b0;
    chk("wr_flushed", 32'(if_valid), 32'd0);
    step();
    chk("wr_refetch_pc", if_pc, 32'h8);
    push_exp(32'h8, gold[2], 1'b0);
    push_exp(32'hC, 32'hDEAD_BEEF, 1'b0);
    push_exp(32'h10, gold[4], 1'b0);
    if_ready = 1'b1;
    for (int k = 0; k < 3; k++) step();
    if_ready = 1'b0;
    chk("wr_drained", 32'(exp_q.size()), 32'd0);

    // Redirect and loader write in the same cycle
    redirect_valid = 1'b1; redirect_pc = 32'h14;
    ld_valid = 1'b1; ld_addr = 6'd5; ld_data = 32'hCAFE_F00D; gold[5] = 32'hCAFE_F00D;
    #1;
    chk("rw_mem_we", 32'(mem_we), 32'd1);
    chk("rw_mem_addr", 32'(mem_addr), 32'd5);
    step();
    redirect_valid = 1'b0; ld_valid = 1'b0;
    step();
    chk("rw_pc", if_pc, 32'h14);
    chk("rw_instr", if_instr, 32'hCAFE_F00D);

    // Out-of-range and misaligned PCs
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    step();
    chk("oor_pc", if_pc, 32'h100);
    chk("oor_fault", 32'(if_fault), 32'd1);
    chk("oor_instr", if_instr, NOP);
    redirect_valid = 1'b1; redirect_pc = 32'h6;
    step();
    redirect_valid = 1'b0;
    step();
    chk("mis_pc", if_pc, 32'h6);
    chk("mis_fault", 32'(if_fault), 32'd1);

    // fpc wrap through 2^32
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    push_exp(32'hFFFF_FFFC, NOP, 1'b1);
    push_exp(32'h0, gold[0], 1'b0);
    push_exp(32'h4, gold[1], 1'b0);
    step();
    redirect_valid = 1'b0; if_ready = 1'b1;
    for (int k = 0; k < 12 && exp_q.size() != 0; k++) step();
    chk("wrap_drained", 32'(exp_q.size()), 32'd0);

    // Mid-stream reset
    rst = 1'b1;
    step();
    rst = 1'b0; if_ready = 1'b0;
    exp_q.delete();
    chk("mrst_valid", 32'(if_valid), 32'd0);
    chk("mrst_state", 32'(state_run), 32'd0);
    chk("mrst_pc", if_pc, 32'd0);
    step(); step();
    chk("mrst_no_fetch", 32'(if_valid), 32'd0);
    ld_valid = 1'b1; ld_addr = 6'd0; ld_data = gold[0]; ld_last = 1'b1;
    step();
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("mrst_run", 32'(state_run), 32'd1);
    step();
    chk("mrst_first_valid", 32'(if_valid), 32'd1);
    chk("mrst_first_pc", if_pc, 32'd0);
    chk("mrst_first_instr", if_instr, gold[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
